fpmul_out_stage: RTL and testbench

Registered output stage placed directly downstream of the combinational single-cycle FP32 multiplier. It captures each multiplier result (`product`, `underflow`, `overflow`) under a valid/ready handshake and buffers results in a small FIFO so the consumer can stall. It maintains sticky exception flags and saturating exception counters for the IDPV test harness. It does not alter product bits.

---
 rtl/fpmul_pkg.sv | 22 ++
 rtl/fpmul_fifo.sv | 53 +++++
 rtl/fpmul_out_stage.sv | 75 +++++++
 tb/tb_fpmul_out_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared FP32 field definitions and result/flag types for the multiplier output path.
package fpmul_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int FP_W     = SIGN_W + EXP_W + MAN_W;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fpmul_flags_t;

    typedef struct packed {
        logic [FP_W-1:0] product;
        fpmul_flags_t    flags;
    } fpmul_result_t;

    localparam int RES_W = $bits(fpmul_result_t);

endpackage

// File: rtl/fpmul_fifo.sv
// DEPTH-entry synchronous FIFO of packed multiplier results with valid/ready on both sides.
module fpmul_fifo
    import fpmul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic             push,
    output logic             pop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [RES_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpmul_out_stage.sv
// Registered output stage for the FP32 multiplier: result FIFO plus sticky exception flags and saturating counters.
module fpmul_out_stage
    import fpmul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_product,
    input  logic             in_underflow,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_product,
    output logic [1:0]       out_flags,
    input  logic             sticky_clr,
    output logic             sticky_of,
    output logic             sticky_uf,
    output logic [CNT_W-1:0] of_count,
    output logic [CNT_W-1:0] uf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fpmul_result_t in_res, out_res;
    logic          push, pop;
    logic          push_of, push_uf;

    assign in_res.product        = in_product;
    assign in_res.flags.overflow  = in_overflow;
    assign in_res.flags.underflow = in_underflow;

    fpmul_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_res),
        .push      (push),
        .pop       (pop)
    );

    assign out_product = out_res.product;
    assign out_flags   = out_res.flags;

    assign push_of = push && in_overflow;
    assign push_uf = push && in_underflow;

    // A flagged push in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_of <= 1'b0;
            sticky_uf <= 1'b0;
            of_count  <= '0;
            uf_count  <= '0;
        end else begin
            if (push_of)         sticky_of <= 1'b1;
            else if (sticky_clr) sticky_of <= 1'b0;
            if (push_uf)         sticky_uf <= 1'b1;
            else if (sticky_clr) sticky_uf <= 1'b0;

            if (sticky_clr)                        of_count <= push_of ? CNT_W'(1) : '0;
            else if (push_of && of_count != CNT_MAX) of_count <= of_count + CNT_W'(1);
            if (sticky_clr)                        uf_count <= push_uf ? CNT_W'(1) : '0;
            else if (push_uf && uf_count != CNT_MAX) uf_count <= uf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fpmul_out_stage.sv
// Self-checking bench for fpmul_out_stage: directed scenarios plus a randomized run against a queue model.
module tb_fpmul_out_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [31:0]      in_product = '0;
    logic             in_underflow = 1'b0, in_overflow = 1'b0;
    logic             out_valid, out_ready = 1'b0;
    logic [31:0]      out_product;
    logic [1:0]       out_flags;
    logic             sticky_clr = 1'b0;
    logic             sticky_of, sticky_uf;
    logic [CNT_W-1:0] of_count, uf_count;

    fpmul_out_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .in_underflow(in_underflow), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_flags(out_flags),
        .sticky_clr(sticky_clr), .sticky_of(sticky_of), .sticky_uf(sticky_uf),
        .of_count(of_count), .uf_count(uf_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: entries are {product, overflow, underflow}
    logic [33:0] q[$];
    bit m_sof, m_suf;
    int m_ofc, m_ufc;

    function automatic void model_clear();
        q.delete();
        m_sof = 0; m_suf = 0; m_ofc = 0; m_ufc = 0;
    endfunction

    // One clock; model follows the handshake rules, then settle 1 time unit after the edge.
    task automatic tick();
        bit push, pop, of, uf, clr;
        logic [31:0] p;
        push = in_valid && (q.size() != DEPTH);
        pop  = out_ready && (q.size() != 0);
        p = in_product; of = in_overflow; uf = in_underflow; clr = sticky_clr;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back({p, of, uf});
        if (clr) begin m_sof = 0; m_suf = 0; m_ofc = 0; m_ufc = 0; end
        if (push && of) begin m_sof = 1; m_ofc = (m_ofc >= CMAX) ? CMAX : m_ofc + 1; end
        if (push && uf) begin m_suf = 1; m_ufc = (m_ufc >= CMAX) ? CMAX : m_ufc + 1; end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] p, input bit of, input bit uf);
        in_valid = v; in_product = p; in_overflow = of; in_underflow = uf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_tests++;
        if ({in_ready, out_valid, out_product, out_flags} !== {1'b1, 1'b0, 32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b prod=%h fl=%b, want rdy=1 vld=0 prod=0 fl=00",
                     in_ready, out_valid, out_product, out_flags);
        end
        n_tests++;
        if ({sticky_of, sticky_uf, of_count, uf_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_sticky: got sof=%b suf=%b ofc=%0d ufc=%0d, want all 0",
                     sticky_of, sticky_uf, of_count, uf_count);
        end
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        drive(1, 32'h40C00000, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0);
        n_tests++;
        if ({out_valid, out_product, out_flags} !== {1'b1, 32'h40C00000, 2'b00}) begin
            n_fail++;
            $display("FAIL single_out: got vld=%b prod=%h fl=%b, want vld=1 prod=40c00000 fl=00",
                     out_valid, out_product, out_flags);
        end
        n_tests++;
        if (of_count !== 0 || uf_count !== 0) begin
            n_fail++;
            $display("FAIL single_counts: got ofc=%0d ufc=%0d, want 0 0", of_count, uf_count);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got vld=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1, 32'h3F800000, 0, 0); tick();
        drive(1, 32'h40000000, 0, 0); tick();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got in_ready=%b, want 0", in_ready);
        end
        drive(1, 32'h40400000, 0, 0); tick();
        drive(0, 32'h0, 0, 0);
        n_tests++;
        if (out_product !== 32'h3F800000 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got prod=%h rdy=%b, want prod=3f800000 rdy=0", out_product, in_ready);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if ({out_valid, out_product, in_ready} !== {1'b1, 32'h40000000, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_pop1: got vld=%b prod=%h rdy=%b, want vld=1 prod=40000000 rdy=1",
                     out_valid, out_product, in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_dropped: got vld=%b, want 0 (third push must be ignored)", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] vals[8];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vals[i] = (i == 3) ? 32'h0 : $urandom;
            drive(1, vals[i], 0, 0);
            tick();
            n_tests++;
            if ({out_valid, out_product, in_ready} !== {1'b1, vals[i], 1'b1}) begin
                n_fail++;
                $display("FAIL stream_%0d: got vld=%b prod=%h rdy=%b, want vld=1 prod=%h rdy=1",
                         i, out_valid, out_product, in_ready, vals[i]);
            end
        end
        drive(0, 32'h0, 0, 0);
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got vld=%b, want 0", out_valid);
        end
    endtask

    task automatic test_exceptions();
        out_ready = 1'b1;
        sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin drive(1, $urandom, 1, 0); tick(); end
        drive(1, 32'h00000000, 0, 1); tick();
        drive(0, 32'h0, 0, 0);
        n_tests++;
        if ({of_count, uf_count, sticky_of, sticky_uf} !== {4'd3, 4'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL exc_count: got ofc=%0d ufc=%0d sof=%b suf=%b, want 3 1 1 1",
                     of_count, uf_count, sticky_of, sticky_uf);
        end
        n_tests++;
        if ({out_product, out_flags} !== {32'h0, 2'b01}) begin
            n_fail++;
            $display("FAIL exc_zero_uf: got prod=%h fl=%b, want 00000000 01", out_product, out_flags);
        end
        sticky_clr = 1'b1;
        drive(1, 32'h7F7FFFFF, 1, 0);
        tick();
        sticky_clr = 1'b0;
        drive(0, 32'h0, 0, 0);
        n_tests++;
        if ({sticky_of, of_count, sticky_uf, uf_count} !== {1'b1, 4'd1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL exc_clr_push: got sof=%b ofc=%0d suf=%b ufc=%0d, want 1 1 0 0",
                     sticky_of, of_count, sticky_uf, uf_count);
        end
        n_tests++;
        if (out_flags !== 2'b10) begin
            n_fail++;
            $display("FAIL exc_flags: got fl=%b, want 10", out_flags);
        end
        tick();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
        drive(1, 32'h12345678, 1, 1); tick();
        n_tests++;
        if ({of_count, uf_count, out_flags} !== {4'd1, 4'd1, 2'b11}) begin
            n_fail++;
            $display("FAIL both_flags: got ofc=%0d ufc=%0d fl=%b, want 1 1 11", of_count, uf_count, out_flags);
        end
        for (int i = 1; i < 20; i++) begin
            drive(1, $urandom, 1, 0);
            tick();
            if (i == 14 || i == 19) begin
                n_tests++;
                if (of_count !== 4'd15) begin
                    n_fail++;
                    $display("FAIL sat_%0d: got ofc=%0d, want 15", i + 1, of_count);
                end
            end
        end
        drive(0, 32'h0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            out_ready  = $urandom_range(0, 2) != 0;
            sticky_clr = $urandom_range(0, 15) == 0;
            tick();
            n_tests++;
            if (in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0)
                || (q.size() != 0 && {out_product, out_flags} !== q[0])
                || sticky_of !== m_sof || sticky_uf !== m_suf
                || of_count !== CNT_W'(m_ofc) || uf_count !== CNT_W'(m_ufc)) begin
                n_fail++;
                if (bad++ < 5)
                    $display("FAIL random_c%0d: got rdy=%b vld=%b data=%h sof=%b suf=%b ofc=%0d ufc=%0d, want occ=%0d head=%h sof=%b suf=%b ofc=%0d ufc=%0d",
                             c, in_ready, out_valid, {out_product, out_flags}, sticky_of, sticky_uf,
                             of_count, uf_count, q.size(), (q.size() != 0) ? q[0] : 34'h0,
                             m_sof, m_suf, m_ofc, m_ufc);
            end
        end
        drive(0, 32'h0, 0, 0);
        sticky_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1, 32'hC0A00000, 1, 0); tick();
        drive(1, 32'h3E000000, 0, 1); tick();
        drive(0, 32'h0, 0, 0);
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_pre: got vld=%b rdy=%b, want 1 0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: got vld=%b, want 0 right after reset asserts", out_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if ({in_ready, out_valid, out_product, out_flags, sticky_of, sticky_uf, of_count, uf_count}
            !== {1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL rmid_after: got rdy=%b vld=%b prod=%h fl=%b sof=%b suf=%b ofc=%0d ufc=%0d, want rdy=1 rest 0",
                     in_ready, out_valid, out_product, out_flags, sticky_of, sticky_uf, of_count, uf_count);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_empty: got vld=%b, want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_exceptions();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
